// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the RV32M multiply/divide unit.
// Holds the funct3 operation codes, FSM state encoding, default widths and
// small decode helpers used by muldiv_unit and muldiv_iter.
package muldiv_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_RD_W = 5;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // All divide/remainder encodings have funct3[2] set.
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_signed_a(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: combinational single-step datapath for muldiv_unit.
// Ports:
//   div_mode  - 1: restoring-divide step, 0: shift-add multiply step
//   acc_hi    - upper accumulator (partial product high / partial remainder)
//   acc_lo    - lower accumulator (multiplier bits / dividend-quotient bits)
//   operand   - multiplicand magnitude or divisor magnitude
//   next_hi   - accumulator high after this step
//   next_lo   - accumulator low after this step
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic            div_mode,
  input  logic [XLEN-1:0] acc_hi,
  input  logic [XLEN-1:0] acc_lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] next_hi,
  output logic [XLEN-1:0] next_lo
);

  logic [XLEN:0] addend;
  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Multiply: add the multiplicand when the current multiplier LSB is set,
  // then shift the whole {carry, hi, lo} right by one.
  // Divide: shift {hi, lo} left, trial-subtract the divisor from the partial
  // remainder; a borrow (diff MSB) means restore and record a 0 quotient bit.
  // The partial remainder stays below the divisor, so the trial difference
  // always fits in XLEN bits when no borrow occurs.
  always_comb begin
    addend  = '0;
    sum     = '0;
    shifted = '0;
    diff    = '0;
    next_hi = acc_hi;
    next_lo = acc_lo;
    if (div_mode) begin
      shifted = {acc_hi, acc_lo[XLEN-1]};
      diff    = shifted - {1'b0, operand};
      if (diff[XLEN]) begin
        next_hi = shifted[XLEN-1:0];
        next_lo = {acc_lo[XLEN-2:0], 1'b0};
      end else begin
        next_hi = diff[XLEN-1:0];
        next_lo = {acc_lo[XLEN-2:0], 1'b1};
      end
    end else begin
      if (acc_lo[0]) begin
        addend = {1'b0, operand};
      end
      sum     = {1'b0, acc_hi} + addend;
      next_hi = sum[XLEN:1];
      next_lo = {sum[0], acc_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide execute unit.
// One bit per cycle on operand magnitudes, sign fix-up on the final step,
// fast path for divide-by-zero and signed overflow.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   valid_i / ready_o   - request handshake (ready only in IDLE)
//   kill_i              - pipeline flush, aborts an op in CALC
//   op_i                - funct3 operation select
//   rs1_data_i/rs2_data_i - operands A and B
//   rd_i                - destination register index
//   busy_o              - op in flight
//   done_o / regwrite_o - one-cycle completion and write strobe
//   rd_o / result_o     - registered destination and result, held until next completion
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int RD_W  = DEF_RD_W,
  parameter int ITERS = DEF_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            kill_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [RD_W-1:0] rd_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            regwrite_o,
  output logic [RD_W-1:0] rd_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(ITERS);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_next;

  logic [2:0]      op_q;
  logic [RD_W-1:0] rd_q;
  logic [XLEN-1:0] opnd_q, hi_q, lo_q;
  logic            neg_main_q, neg_rem_q;
  logic [CNT_W-1:0] cnt_q;

  logic            accept, last_iter;
  logic            a_neg, b_neg, div_by_zero, sgn_overflow, fast_path;
  logic [XLEN-1:0] a_mag, b_mag, fast_result;
  logic [XLEN-1:0] next_hi, next_lo;
  logic [2*XLEN-1:0] product, product_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, calc_result;

  assign accept    = (state == IDLE) && valid_i && !kill_i;
  assign last_iter = (state == CALC) && (cnt_q == CNT_W'(ITERS - 1));

  // Decode of the incoming request: operand magnitudes, and the two divide
  // corner cases that are answered directly without iterating.
  always_comb begin
    a_neg        = op_signed_a(op_i) && rs1_data_i[XLEN-1];
    b_neg        = op_signed_b(op_i) && rs2_data_i[XLEN-1];
    a_mag        = a_neg ? -rs1_data_i : rs1_data_i;
    b_mag        = b_neg ? -rs2_data_i : rs2_data_i;
    div_by_zero  = is_div(op_i) && (rs2_data_i == '0);
    sgn_overflow = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                   (rs1_data_i == MIN_NEG) && (rs2_data_i == '1);
    fast_path    = div_by_zero || sgn_overflow;
    fast_result  = '0;
    if (div_by_zero) begin
      fast_result = op_i[1] ? rs1_data_i : '1;
    end else if (sgn_overflow) begin
      fast_result = op_i[1] ? '0 : MIN_NEG;
    end
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .div_mode (is_div(op_q)),
    .acc_hi   (hi_q),
    .acc_lo   (lo_q),
    .operand  (opnd_q),
    .next_hi  (next_hi),
    .next_lo  (next_lo)
  );

  // Sign fix-up applied to the output of the last step, so the result is
  // registered on the same edge the iteration finishes.
  always_comb begin
    product     = {next_hi, next_lo};
    product_fix = neg_main_q ? -product : product;
    quot_fix    = neg_main_q ? -next_lo : next_lo;
    rem_fix     = neg_rem_q ? -next_hi : next_hi;
    case (op_q)
      OP_MUL:                       calc_result = product_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_result = product_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              calc_result = quot_fix;
      default:                      calc_result = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake/status outputs. kill_i only matters in IDLE
  // (blocks acceptance) and CALC (aborts); DONE always lasts one cycle.
  always_comb begin
    state_next = state;
    ready_o    = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    regwrite_o = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (accept) begin
          state_next = fast_path ? DONE : CALC;
        end
      end
      CALC: begin
        busy_o = 1'b1;
        if (kill_i) begin
          state_next = IDLE;
        end else if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy_o     = 1'b1;
        done_o     = 1'b1;
        regwrite_o = (rd_o != '0);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch on accept, one iteration per CALC cycle, and the
  // completion registers that hold rd/result until the next completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q       <= '0;
      rd_q       <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      cnt_q      <= '0;
      rd_o       <= '0;
      result_o   <= '0;
    end else if (accept) begin
      op_q       <= op_i;
      rd_q       <= rd_i;
      hi_q       <= '0;
      lo_q       <= is_div(op_i) ? a_mag : b_mag;
      opnd_q     <= is_div(op_i) ? b_mag : a_mag;
      neg_main_q <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
      cnt_q      <= '0;
      if (fast_path) begin
        rd_o     <= rd_i;
        result_o <= fast_result;
      end
    end else if ((state == CALC) && !kill_i) begin
      hi_q  <= next_hi;
      lo_q  <= next_lo;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_iter) begin
        rd_o     <= rd_q;
        result_o <= calc_result;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit.
// A cycle-level reference model (plain integer arithmetic plus a pending-op
// record) is compared against the DUT on every falling edge; directed
// vectors additionally check results and latencies against literals.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic        kill_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_i;
  logic        busy_o;
  logic        done_o;
  logic        regwrite_o;
  logic [4:0]  rd_o;
  logic [31:0] result_o;

  int n_vec  = 0;
  int n_fail = 0;

  // reference model state
  int          cyc = 0;
  int          done_edge = 0;
  bit          pending = 1'b0;
  logic [31:0] q_res = '0;
  logic [31:0] exp_res = '0;
  logic [4:0]  q_rd = '0;
  logic [4:0]  exp_rd = '0;

  muldiv_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .kill_i     (kill_i),
    .op_i       (op_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_i       (rd_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .regwrite_o (regwrite_o),
    .rd_o       (rd_o),
    .result_o   (result_o)
  );

  always #5 clk = ~clk;

  // Architectural RV32M result, computed from 64-bit integer arithmetic.
  function automatic logic [31:0] model_result(input logic [2:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'h0 : 32'($signed(a) % $signed(b)));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit model_fast(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return op[2] && ((b == 0) ||
           (((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model update on each rising edge: reset, completion, abort or accept.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      pending = 1'b0;
      exp_rd  = '0;
      exp_res = '0;
    end else if (pending) begin
      if (cyc - 1 == done_edge) pending = 1'b0;
      else if (kill_i)          pending = 1'b0;
    end else if (valid_i && !kill_i) begin
      pending   = 1'b1;
      q_res     = model_result(op_i, rs1_data_i, rs2_data_i);
      q_rd      = rd_i;
      done_edge = model_fast(op_i, rs1_data_i, rs2_data_i) ? cyc : cyc + 32;
    end
    if (pending && (cyc == done_edge)) begin
      exp_rd  = q_rd;
      exp_res = q_res;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (cyc > 0) begin
      checkOutput("cmp_ready",    ready_o,    !pending);
      checkOutput("cmp_busy",     busy_o,     pending);
      checkOutput("cmp_done",     done_o,     pending && (cyc == done_edge));
      checkOutput("cmp_regwrite", regwrite_o, pending && (cyc == done_edge) && (exp_rd != 0));
      checkOutput("cmp_rd",       rd_o,       exp_rd);
      checkOutput("cmp_result",   result_o,   exp_res);
    end
  end

  // Present a request and hold it until the unit takes it; returns the
  // model cycle number of the accepting edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               output int acc_cyc);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    op_i = op; rs1_data_i = a; rs2_data_i = b; rd_i = rd; valid_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (ready_o && !kill_i) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checkOutput("accept_seen", ok, 1'b1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    valid_i = 1'b0;
  endtask

  task automatic waitDone(output int done_cyc, output logic rw,
                          output logic [4:0] rd, output logic [31:0] res);
    bit ok;
    ok = 1'b0;
    done_cyc = 0; rw = 1'b0; rd = '0; res = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_o) begin
        ok = 1'b1; done_cyc = cyc; rw = regwrite_o; rd = rd_o; res = result_o;
        break;
      end
    end
    checkOutput("done_seen", ok, 1'b1);
  endtask

  task automatic runOp(input string name, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat);
    int acc, dn;
    logic rw;
    logic [4:0] r;
    logic [31:0] res;
    applyStimulus(op, a, b, rd, acc);
    waitDone(dn, rw, r, res);
    checkOutput({name, "_result"}, res, exp);
    checkOutput({name, "_rd"}, r, rd);
    checkOutput({name, "_regwrite"}, rw, rd != 0);
    checkOutput({name, "_latency"}, dn - acc + 1, lat);
  endtask

  task automatic countDones(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (done_o) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc, acc2, dn, cnt;
    logic rw;
    logic [4:0] r;
    logic [31:0] res;

    rst_n = 1'b0; valid_i = 1'b0; kill_i = 1'b0;
    op_i = '0; rs1_data_i = '0; rs2_data_i = '0; rd_i = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", ready_o, 1);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_regwrite", regwrite_o, 0);
    checkOutput("rst_rd", rd_o, 0);
    checkOutput("rst_result", result_o, 0);
    rst_n = 1'b1;

    // kill_i in IDLE blocks acceptance
    @(negedge clk);
    op_i = 3'd0; rs1_data_i = 32'd3; rs2_data_i = 32'd3; rd_i = 5'd1;
    valid_i = 1'b1; kill_i = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_kill_busy", busy_o, 0);
    checkOutput("idle_kill_ready", ready_o, 1);
    valid_i = 1'b0; kill_i = 1'b0;

    runOp("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
    runOp("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 33);
    runOp("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 33);
    runOp("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 33);
    runOp("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         5'd9, 32'hFFFF_FFFD, 33);
    runOp("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 33);
    runOp("divu",   3'd5, 32'd100,       32'd7,         5'd11, 32'd14, 33);
    runOp("remu",   3'd7, 32'd100,       32'd7,         5'd12, 32'd2, 33);
    runOp("div0",   3'd4, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1);
    runOp("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
    runOp("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 1);

    // REM by zero with kill_i raised during its DONE cycle: no effect
    applyStimulus(3'd6, 32'd5, 32'd0, 5'd14, acc);
    kill_i = 1'b1;
    waitDone(dn, rw, r, res);
    kill_i = 1'b0;
    checkOutput("rem0_result", res, 32'd5);
    checkOutput("rem0_latency", dn - acc + 1, 1);

    // kill_i at T+10 of a DIVU
    applyStimulus(3'd5, 32'd1000, 32'd3, 5'd17, acc);
    @(negedge clk);
    while (cyc < acc + 9) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    checkOutput("kill_ready", ready_o, 1);
    checkOutput("kill_busy", busy_o, 0);
    countDones(40, cnt);
    checkOutput("kill_no_done", cnt, 0);

    // reset at T+5 of a MUL
    applyStimulus(3'd0, 32'd9, 32'd9, 5'd18, acc);
    @(negedge clk);
    while (cyc < acc + 4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_ready", ready_o, 1);
    checkOutput("midrst_busy", busy_o, 0);
    checkOutput("midrst_done", done_o, 0);
    checkOutput("midrst_rd", rd_o, 0);
    checkOutput("midrst_result", result_o, 0);
    rst_n = 1'b1;
    countDones(40, cnt);
    checkOutput("midrst_no_done", cnt, 0);

    // rd=0 completes without a register write
    runOp("mul_rd0", 3'd0, 32'd6, 32'd7, 5'd0, 32'd42, 33);

    // second request held through CALC/DONE is taken in the first IDLE cycle
    applyStimulus(3'd0, 32'd3, 32'd4, 5'd19, acc);
    applyStimulus(3'd3, 32'h8000_0000, 32'd4, 5'd20, acc2);
    checkOutput("held_accept_gap", acc2 - acc, 34);
    waitDone(dn, rw, r, res);
    checkOutput("held_result", res, 32'd2);
    checkOutput("held_rd", r, 5'd20);
    checkOutput("held_latency", dn - acc2 + 1, 33);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
